// File: rtl/accumulator_pkg.sv
// Shared types and constants for the accumulator load-stream source.
package accumulator_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam logic [15:0] LFSR_TAPS        = 16'hB400;
    localparam int          DEFAULT_DATA_W   = 32;
    localparam int          DEFAULT_SAMPLE_W = 16;

    // One step of the 16-bit right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/accumulator_load_source_if.sv
// Accumulator data bus: samples flow out on load, the checked sum returns on result.
interface accumulator_load_source_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] load;
    logic [DATA_W-1:0] result;
    logic              result_valid;

    // Source side: drives samples, observes the accumulator result.
    modport master (
        output load,
        input  result,
        input  result_valid
    );

    // Accumulator side: consumes samples, reports its result.
    modport slave (
        input  load,
        output result,
        output result_valid
    );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR; a zero seed is replaced by 1 so the register never locks up.
module lfsr16
    import accumulator_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    // Next LFSR value, used only when advance is asserted.
    always_comb begin
        value_d = lfsr_next(value_q);
    end

    // Shift register: re-seeds on reset, steps on advance.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            value_q <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else if (advance) begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/accumulator_load_source.sv
// Hardware stimulus source for the accumulator: streams COUNT LFSR samples on
// load, keeps a golden sum, then checks the accumulator's result against it.
module accumulator_load_source
    import accumulator_pkg::*;
#(
    parameter int          DATA_W   = DEFAULT_DATA_W,
    parameter int          SAMPLE_W = DEFAULT_SAMPLE_W,
    parameter int          COUNT    = 1023,
    parameter logic [15:0] SEED     = 16'h0001,
    parameter int          TIMEOUT  = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    accumulator_load_source_if.master acc,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      timed_out,
    output logic [DATA_W-1:0]         expected_sum
);

    localparam int CNT_W = $clog2(COUNT + 1);
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] COUNT_LAST   = CNT_W'(COUNT);
    localparam logic [TO_W-1:0]  TIMEOUT_LAST = TO_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] load_q, load_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic              pass_q, pass_d;
    logic              to_q, to_d;

    logic [15:0]       lfsr_value;
    logic              lfsr_advance;
    logic [DATA_W-1:0] sample;
    logic              start_ok;
    logic              stream_end;
    logic              wait_expire;

    lfsr16 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .seed    (SEED),
        .advance (lfsr_advance),
        .value   (lfsr_value)
    );

    assign sample      = DATA_W'(lfsr_value[SAMPLE_W-1:0]);
    assign start_ok    = start && (state_q == S_IDLE || state_q == S_DONE);
    assign stream_end  = (cnt_q == COUNT_LAST);
    assign wait_expire = (tcnt_q == TIMEOUT_LAST);

    // State and datapath registers; reset abandons any run in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            load_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            pass_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            pass_q  <= pass_d;
            to_q    <= to_d;
        end
    end

    // Next-state logic; start is honoured only in IDLE and DONE.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_ok) state_d = S_STREAM;
            S_STREAM:       if (stream_end) state_d = S_WAIT;
            S_WAIT:         if (acc.result_valid || wait_expire) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    // Datapath: sample emission, golden sum, timeout and result check.
    always_comb begin
        load_d       = load_q;
        sum_d        = sum_q;
        cnt_d        = cnt_q;
        tcnt_d       = tcnt_q;
        pass_d       = pass_q;
        to_d         = to_q;
        lfsr_advance = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    load_d       = sample;
                    sum_d        = sample;
                    cnt_d        = CNT_W'(1);
                    lfsr_advance = 1'b1;
                    pass_d       = 1'b0;
                    to_d         = 1'b0;
                end
            end
            S_STREAM: begin
                if (stream_end) begin
                    load_d = '0;
                    tcnt_d = '0;
                end else begin
                    load_d       = sample;
                    sum_d        = sum_q + sample;
                    cnt_d        = cnt_q + CNT_W'(1);
                    lfsr_advance = 1'b1;
                end
            end
            S_WAIT: begin
                if (acc.result_valid) begin
                    pass_d = (acc.result == sum_q);
                end else if (wait_expire) begin
                    to_d   = 1'b1;
                    pass_d = 1'b0;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            default: load_d = '0;
        endcase
    end

    assign acc.load     = load_q;
    assign busy         = (state_q == S_STREAM) || (state_q == S_WAIT);
    assign done         = (state_q == S_DONE);
    assign pass         = pass_q;
    assign timed_out    = to_q;
    assign expected_sum = sum_q;

endmodule
